// File: rtl/rt_delay_pkg.sv
// Shared definitions for the rt_delay_ctrl / rt_var_delay pair.
// Holds the controller state encoding and the default delay width.
package rt_delay_pkg;

   localparam int DELAY_W_DEF = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/rt_step_timer.sv
// Loadable down-counter that times the settle interval between steps.
// Ports: clk, rst (sync, high), en, load, load_val -> zero flag.
module rt_step_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (en) begin
         if (load)
            cnt_q <= load_val;
         else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/rt_delay_ctrl.sv
// Slewing controller for rt_var_delay: clamps a requested delay and
// walks the applied delay toward it one tap at a time.
// Ports: clk, rst, en, req_valid/req_delay/req_ready handshake,
//        delay (to rt_var_delay), busy, done and clamped pulses.
module rt_delay_ctrl
   import rt_delay_pkg::*;
#(
   parameter int DELAY_WIDTH   = DELAY_W_DEF,
   parameter int MAX_DELAY     = 24,
   parameter int INITIAL_DELAY = 3,
   parameter int STEP_INTERVAL = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   req_valid,
   input  logic [DELAY_WIDTH-1:0] req_delay,
   output logic                   req_ready,
   output logic [DELAY_WIDTH-1:0] delay,
   output logic                   busy,
   output logic                   done,
   output logic                   clamped
);

   localparam int TW = $clog2(STEP_INTERVAL) + 1;
   localparam logic [DELAY_WIDTH-1:0] MAXD = DELAY_WIDTH'(MAX_DELAY);
   localparam logic [DELAY_WIDTH-1:0] INITD = DELAY_WIDTH'(INITIAL_DELAY);
   localparam logic [TW-1:0] RELOAD = TW'(STEP_INTERVAL - 1);

   state_t                 state_q;
   state_t                 state_d;
   logic [DELAY_WIDTH-1:0] delay_q;
   logic [DELAY_WIDTH-1:0] target_q;
   logic [DELAY_WIDTH-1:0] clamp_t;
   logic                   over;
   logic                   accept;
   logic                   ld;
   logic                   zero;

   assign over      = (req_delay > MAXD);
   assign clamp_t   = over ? MAXD : req_delay;
   assign req_ready = (state_q == IDLE) & en;
   assign accept    = req_valid & req_ready;
   assign ld        = en & (state_q == STEP);

   assign delay = delay_q;
   assign busy  = (state_q == STEP) | (state_q == WAIT);

   rt_step_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (ld),
      .load_val (RELOAD),
      .zero     (zero)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept)
               state_d = (clamp_t == delay_q) ? DONE : STEP;
         end
         STEP: state_d = WAIT;
         WAIT: begin
            if (zero)
               state_d = (delay_q == target_q) ? DONE : STEP;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // done/clamped are registered pulses so they clear even while en=0
   // holds the FSM in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         delay_q  <= INITD;
         target_q <= INITD;
         done     <= 1'b0;
         clamped  <= 1'b0;
      end else begin
         done    <= 1'b0;
         clamped <= 1'b0;
         if (en) begin
            state_q <= state_d;
            done    <= (state_d == DONE) && (state_q != DONE);
            if (accept) begin
               target_q <= clamp_t;
               clamped  <= over;
            end
            // STEP is only entered with target != delay, so this
            // never moves past 0 or MAX_DELAY.
            if (state_q == STEP) begin
               if (target_q > delay_q)
                  delay_q <= delay_q + 1'b1;
               else
                  delay_q <= delay_q - 1'b1;
            end
         end
      end
   end

endmodule
